// File: rtl/control_unit_pkg.sv
// Shared types and constants for the block transfer sequencer: FSM state
// encoding, register-file size and the {pre,up} addressing-mode codes.
package control_unit_pkg;

  localparam int NUM_REGS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_WBACK,
    S_FINISH
  } bts_state_t;

  // Mode is packed as {pre, up}.
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_DA = 2'b00;
  localparam mode_t MODE_IA = 2'b01;
  localparam mode_t MODE_DB = 2'b10;
  localparam mode_t MODE_IB = 2'b11;

endpackage

// File: rtl/block_transfer_sequencer_if.sv
// Command and memory-side signals of the block transfer sequencer.
// The slave modport is the sequencer; master is whoever drives it.
interface block_transfer_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic [15:0]       reg_list;
  logic [ADDR_W-1:0] base_addr;
  logic              load;
  logic              up;
  logic              pre;
  logic              writeback;
  logic              mem_ready;
  logic              busy;
  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        reg_addr;
  logic              reg_we;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_value;
  logic              done;

  modport slave (
    input  start, reg_list, base_addr, load, up, pre, writeback, mem_ready,
    output busy, mem_req, mem_rw, mem_addr, reg_addr, reg_we, wb_en, wb_value, done
  );

  modport master (
    output start, reg_list, base_addr, load, up, pre, writeback, mem_ready,
    input  busy, mem_req, mem_rw, mem_addr, reg_addr, reg_we, wb_en, wb_value, done
  );
endinterface

// File: rtl/lowest_set_finder.sv
// Combinational priority encoder: index of the lowest set bit of a
// register mask, plus a flag telling whether any bit is set.
module lowest_set_finder
  import control_unit_pkg::*;
(
  input  logic [NUM_REGS-1:0] mask,
  output logic [3:0]          idx,
  output logic                any
);

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    any = |mask;
  end

endmodule

// File: rtl/block_transfer_sequencer.sv
// Clocked load/store-multiple sequencer: walks the register list lowest bit
// first, issues one handshaked word transfer per register, then writes back.
module block_transfer_sequencer
  import control_unit_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input logic                      clk,
  input logic                      reset_n,
  block_transfer_sequencer_if.slave bus
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

  bts_state_t          state, state_nxt;
  logic [NUM_REGS-1:0] mask;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   wb_val_q;
  logic                load_q;
  logic                wb_q;
  mode_t               mode_q;

  logic [3:0]          low_idx;
  logic                low_any;
  logic [NUM_REGS-1:0] onehot;
  logic [NUM_REGS-1:0] mask_after;
  logic [4:0]          n;
  logic [ADDR_W-1:0]   span;
  logic [ADDR_W-1:0]   first_addr;
  logic [ADDR_W-1:0]   wb_calc;
  logic                xfer;

  lowest_set_finder u_finder (
    .mask (mask),
    .idx  (low_idx),
    .any  (low_any)
  );

  always_comb begin
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) n = n + 5'(mask[i]);
    span = ADDR_W'(n) * STRIDE;

    // Addresses always ascend, so decrementing modes start below the base.
    case (mode_q)
      MODE_IA: first_addr = base_q;
      MODE_IB: first_addr = base_q + STRIDE;
      MODE_DA: first_addr = base_q - span + STRIDE;
      default: first_addr = base_q - span;
    endcase
    wb_calc = mode_q[0] ? base_q + span : base_q - span;

    onehot          = '0;
    onehot[low_idx] = 1'b1;
    mask_after      = mask & ~onehot;
    xfer            = (state == S_ISSUE) && bus.mem_ready;
  end

  // NOTE: reset is synchronous, so it sits inside the clocked branch rather
  // than in the sensitivity list; sequential state uses <= only.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = (n == 5'd0) ? S_FINISH : S_ISSUE;
      S_ISSUE:  if (xfer && !(|mask_after)) state_nxt = wb_q ? S_WBACK : S_FINISH;
      S_WBACK:  state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask     <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      wb_val_q <= '0;
      load_q   <= 1'b0;
      wb_q     <= 1'b0;
      mode_q   <= MODE_DA;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          mask   <= bus.reg_list;
          base_q <= bus.base_addr;
          load_q <= bus.load;
          wb_q   <= bus.writeback;
          mode_q <= {bus.pre, bus.up};
        end
        S_SETUP: begin
          addr_q   <= first_addr;
          wb_val_q <= wb_calc;
        end
        S_ISSUE: if (xfer) begin
          mask   <= mask_after;
          addr_q <= addr_q + STRIDE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy     = (state != S_IDLE);
    bus.mem_req  = 1'b0;
    bus.mem_rw   = 1'b0;
    bus.mem_addr = '0;
    bus.reg_addr = '0;
    bus.reg_we   = 1'b0;
    bus.wb_en    = 1'b0;
    bus.wb_value = '0;
    bus.done     = 1'b0;
    case (state)
      S_ISSUE: begin
        bus.mem_req  = low_any;
        bus.mem_rw   = load_q;
        bus.mem_addr = addr_q;
        bus.reg_addr = low_idx;
        bus.reg_we   = load_q & bus.mem_ready;
      end
      S_WBACK: begin
        bus.wb_en    = 1'b1;
        bus.wb_value = wb_val_q;
      end
      S_FINISH: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
